// File: rtl/eeprom_preload_ctrl.sv
// Boot-time image loader: reads NUM_WORDS words byte-by-byte from a serial EEPROM,
// writes them to boot memory and releases the core reset once the image is complete.
module eeprom_preload_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_WORDS   = 256,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned MAX_RETRIES = 3,
  localparam int unsigned ADDR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              rd_req_valid_o,
  input  logic              rd_req_ready_i,
  output logic [15:0]       rd_req_addr_o,
  input  logic              rd_rsp_valid_i,
  input  logic [7:0]        rd_rsp_data_i,
  input  logic              rd_rsp_err_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              core_rst_no
);

  localparam int unsigned BPW     = WIDTH / 8;
  localparam int unsigned BYTE_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(BPW - 1);
  localparam logic [ADDR_W-1:0]  LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  // The whole image must fit the 16-bit EEPROM space without wrapping.
  if ((WIDTH % 8 != 0) || (WIDTH < 8) || (WIDTH > 64) || (NUM_WORDS < 1) ||
      (32'(BASE_ADDR) + NUM_WORDS * BPW > 32'd65536)) begin : g_param_err
    $error("eeprom_preload_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   word_r;
  logic [BYTE_W-1:0]   byte_r;
  logic [RETRY_W-1:0]  retry_r;
  logic [15:0]         addr_r;
  logic [WIDTH-1:0]    data_r;
  logic                retry_ok_s;

  assign retry_ok_s = (retry_r < RETRY_MAX);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) state_nxt_s = ST_REQ;
        else         state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (rd_req_ready_i) state_nxt_s = ST_WAIT;
        else                state_nxt_s = ST_REQ;
      end
      ST_WAIT: begin
        if (rd_rsp_valid_i && !rd_rsp_err_i) begin
          if (byte_r == LAST_BYTE) state_nxt_s = ST_WRITE;
          else                     state_nxt_s = ST_REQ;
        end else if (rd_rsp_valid_i) begin
          if (retry_ok_s) state_nxt_s = ST_REQ;
          else            state_nxt_s = ST_FAIL;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (word_r == LAST_WORD) state_nxt_s = ST_DONE;
        else                     state_nxt_s = ST_REQ;
      end
      ST_DONE: state_nxt_s = ST_DONE;
      ST_FAIL: begin
        if (start_i) state_nxt_s = ST_REQ;
        else         state_nxt_s = ST_FAIL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Word/byte/retry counters, running EEPROM address and word assembly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_r  <= '0;
      byte_r  <= '0;
      retry_r <= '0;
      addr_r  <= 16'h0000;
      data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FAIL: begin
          if (start_i) begin
            word_r  <= '0;
            byte_r  <= '0;
            retry_r <= '0;
            addr_r  <= BASE_ADDR;
          end
        end
        ST_WAIT: begin
          if (rd_rsp_valid_i && !rd_rsp_err_i) begin
            data_r[{byte_r, 3'b000} +: 8] <= rd_rsp_data_i;
            retry_r <= '0;
            addr_r  <= addr_r + 16'd1;
            if (byte_r != LAST_BYTE) byte_r <= byte_r + BYTE_W'(1);
          end else if (rd_rsp_valid_i && retry_ok_s) begin
            retry_r <= retry_r + RETRY_W'(1);
          end
        end
        ST_WRITE: begin
          if (word_r != LAST_WORD) begin
            word_r <= word_r + ADDR_W'(1);
            byte_r <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All outputs decode from flops only; no input reaches an output combinationally.
  assign rd_req_valid_o = (state_r == ST_REQ);
  assign rd_req_addr_o  = addr_r;
  assign mem_we_o       = (state_r == ST_WRITE);
  assign mem_addr_o     = word_r;
  assign mem_wdata_o    = data_r;
  assign busy_o         = (state_r == ST_REQ) || (state_r == ST_WAIT) || (state_r == ST_WRITE);
  assign done_o         = (state_r == ST_DONE);
  assign error_o        = (state_r == ST_FAIL);
  assign core_rst_no    = (state_r == ST_DONE);

endmodule

// File: tb/tb_eeprom_preload_ctrl.sv
// Scoreboard bench for eeprom_preload_ctrl: a 4x32-bit loader with retries/stalls
// and a single-byte loader at the top of the EEPROM address space.
module tb_eeprom_preload_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: WIDTH=32, NUM_WORDS=4, BASE=0, MAX_RETRIES=3
  logic        start_a, rdy_a, rv_a, re_a;
  logic [7:0]  rd_a;
  logic        req_v_a, we_a, busy_a, done_a, err_a, crst_a;
  logic [15:0] req_addr_a;
  logic [1:0]  maddr_a;
  logic [31:0] wdata_a;

  eeprom_preload_ctrl #(.WIDTH(32), .NUM_WORDS(4), .BASE_ADDR(16'h0000), .MAX_RETRIES(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
    .rd_req_valid_o(req_v_a), .rd_req_ready_i(rdy_a), .rd_req_addr_o(req_addr_a),
    .rd_rsp_valid_i(rv_a), .rd_rsp_data_i(rd_a), .rd_rsp_err_i(re_a),
    .mem_we_o(we_a), .mem_addr_o(maddr_a), .mem_wdata_o(wdata_a),
    .busy_o(busy_a), .done_o(done_a), .error_o(err_a), .core_rst_no(crst_a));

  // DUT B: WIDTH=8, NUM_WORDS=1, BASE=16'hFFFF
  logic        start_b, rdy_b, rv_b, spur_b;
  logic [7:0]  rd_b;
  logic        req_v_b, we_b, busy_b, done_b, err_b, crst_b;
  logic [15:0] req_addr_b;
  logic [0:0]  maddr_b;
  logic [7:0]  wdata_b;

  eeprom_preload_ctrl #(.WIDTH(8), .NUM_WORDS(1), .BASE_ADDR(16'hFFFF), .MAX_RETRIES(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
    .rd_req_valid_o(req_v_b), .rd_req_ready_i(rdy_b), .rd_req_addr_o(req_addr_b),
    .rd_rsp_valid_i(rv_b | spur_b), .rd_rsp_data_i(rd_b), .rd_rsp_err_i(1'b0),
    .mem_we_o(we_b), .mem_addr_o(maddr_b), .mem_wdata_o(wdata_b),
    .busy_o(busy_b), .done_o(done_b), .error_o(err_b), .core_rst_no(crst_b));

  typedef struct { logic [15:0] addr; logic [63:0] data; } wr_t;
  wr_t q_a[$];
  wr_t q_b[$];
  int  wr_cnt_a = 0;

  // Hand-computed image: byte at address n holds n, words little-endian.
  logic [31:0] img_a [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  int          stall_cycles = 0;
  int          err_left = 0;
  int          t0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word_a(input int w);
    wr_t e;
    e.addr = 16'(w);
    e.data = 64'(img_a[w]);
    q_a.push_back(e);
  endtask

  task automatic push_all_a();
    for (int w = 0; w < 4; w++) push_word_a(w);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_req_valid"}, 64'(req_v_a), 64'd0);
    chk({tag, "_we"},        64'(we_a),    64'd0);
    chk({tag, "_busy"},      64'(busy_a),  64'd0);
    chk({tag, "_done"},      64'(done_a),  64'd0);
    chk({tag, "_error"},     64'(err_a),   64'd0);
    chk({tag, "_core_rst"},  64'(crst_a),  64'd0);
  endtask

  task automatic start_a_pulse();
    @(posedge clk); #1;
    start_a = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("start_busy",     64'(busy_a),     64'd1);
    chk("start_err_low",  64'(err_a),      64'd0);
    chk("start_req_addr", 64'(req_addr_a), 64'h0000);
  endtask

  task automatic wait_end(input bit sel_b, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (sel_b ? (done_b || err_b) : (done_a || err_a)) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) chk("wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every memory write must match the next expected entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (we_a) begin
        wr_cnt_a++;
        if (q_a.size() == 0) chk("a_unexpected_write", 64'(maddr_a), 64'hDEAD);
        else begin
          e = q_a.pop_front();
          chk("a_waddr", 64'(maddr_a), 64'(e.addr));
          chk("a_wdata", 64'(wdata_a), e.data);
        end
      end
      if (we_b) begin
        if (q_b.size() == 0) chk("b_unexpected_write", 64'(maddr_b), 64'hDEAD);
        else begin
          e = q_b.pop_front();
          chk("b_waddr", 64'(maddr_b), 64'(e.addr));
          chk("b_wdata", 64'(wdata_b), e.data);
        end
      end
    end
  end

  // EEPROM responder A: optional stall per request, injected errors at address 5.
  initial begin
    bit          pend = 1'b0;
    logic [15:0] pend_addr = 16'h0;
    logic [15:0] hold_addr = 16'h0;
    int          stall_cnt = 0;
    rdy_a = 1'b0; rv_a = 1'b0; re_a = 1'b0; rd_a = 8'h00;
    forever begin
      @(posedge clk); #1;
      rdy_a = 1'b0; rv_a = 1'b0; re_a = 1'b0; rd_a = 8'h00;
      if (!rst_n) begin
        pend = 1'b0;
        stall_cnt = 0;
      end else if (pend) begin
        rv_a = 1'b1;
        if (pend_addr == 16'd5 && err_left > 0) begin
          re_a = 1'b1;
          rd_a = 8'hEE;
          err_left--;
        end else begin
          rd_a = pend_addr[7:0];
        end
        pend = 1'b0;
      end else if (req_v_a) begin
        if (stall_cnt == 0) hold_addr = req_addr_a;
        else chk("a_addr_stable", 64'(req_addr_a), 64'(hold_addr));
        if (stall_cnt < stall_cycles) stall_cnt++;
        else begin
          rdy_a = 1'b1;
          pend = 1'b1;
          pend_addr = req_addr_a;
          stall_cnt = 0;
        end
      end
    end
  end

  // EEPROM responder B: zero-wait, only 0xFFFF holds 0xA5.
  initial begin
    bit          pend = 1'b0;
    logic [15:0] pend_addr = 16'h0;
    rdy_b = 1'b0; rv_b = 1'b0; rd_b = 8'h00;
    forever begin
      @(posedge clk); #1;
      rdy_b = 1'b0; rv_b = 1'b0; rd_b = 8'h00;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        rv_b = 1'b1;
        rd_b = (pend_addr == 16'hFFFF) ? 8'hA5 : 8'h00;
        pend = 1'b0;
      end else if (req_v_b) begin
        chk("b_req_addr", 64'(req_addr_b), 64'hFFFF);
        rdy_b = 1'b1;
        pend = 1'b1;
        pend_addr = req_addr_b;
      end
    end
  end

  initial begin
    int lat;
    int wr0;
    wr_t e;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; spur_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_idle_a("reset");
    chk("reset_b_core_rst", 64'(crst_b), 64'd0);

    // Zero-wait full load
    push_all_a();
    start_a_pulse();
    wait_end(1'b0, 300, lat);
    chk("t1_latency", 64'(lat), 64'd37);
    chk("t1_done", 64'(done_a), 64'd1);
    chk("t1_core_rst", 64'(crst_a), 64'd1);
    chk("t1_busy", 64'(busy_a), 64'd0);
    chk("t1_q_empty", 64'(q_a.size()), 64'd0);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk); #1;
    chk("done_ignores_start", 64'({done_a, busy_a}), 64'b10);
    apply_reset();

    // Five-cycle ready stall on every request
    stall_cycles = 5;
    push_all_a();
    start_a_pulse();
    wait_end(1'b0, 500, lat);
    chk("t2_latency", 64'(lat), 64'd117);
    chk("t2_q_empty", 64'(q_a.size()), 64'd0);
    stall_cycles = 0;
    apply_reset();

    // Two errors at address 5, then success
    err_left = 2;
    push_all_a();
    start_a_pulse();
    wait_end(1'b0, 300, lat);
    chk("t3_latency", 64'(lat), 64'd41);
    chk("t3_error", 64'(err_a), 64'd0);
    chk("t3_done", 64'(done_a), 64'd1);
    chk("t3_q_empty", 64'(q_a.size()), 64'd0);
    apply_reset();

    // Four errors exhaust retries; restart from FAIL reloads everything
    err_left = 4;
    push_word_a(0);
    start_a_pulse();
    wait_end(1'b0, 300, lat);
    chk("t4_error", 64'(err_a), 64'd1);
    chk("t4_core_rst", 64'(crst_a), 64'd0);
    chk("t4_done", 64'(done_a), 64'd0);
    chk("t4_q_empty", 64'(q_a.size()), 64'd0);
    push_all_a();
    start_a_pulse();
    wait_end(1'b0, 300, lat);
    chk("t4_reload_latency", 64'(lat), 64'd37);
    chk("t4_reload_done", 64'(done_a), 64'd1);
    apply_reset();

    // Reset during word 2 aborts; restart reloads from address 0
    push_all_a();
    wr0 = wr_cnt_a;
    start_a_pulse();
    for (int i = 0; i < 100 && wr_cnt_a < wr0 + 2; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_two_writes", 64'(wr_cnt_a - wr0), 64'd2);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle_a("t5_midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_no_more_writes", 64'(q_a.size()), 64'd2);
    q_a.delete();
    push_all_a();
    start_a_pulse();
    wait_end(1'b0, 300, lat);
    chk("t5_reload_latency", 64'(lat), 64'd37);
    chk("t5_q_empty", 64'(q_a.size()), 64'd0);

    // Single-byte loader at 0xFFFF, spurious response in IDLE first
    @(posedge clk); #1 spur_b = 1'b1;
    @(posedge clk); #1 spur_b = 1'b0;
    chk("b_idle_busy", 64'({busy_b, req_v_b}), 64'd0);
    e.addr = 16'h0000;
    e.data = 64'h00000000000000A5;
    q_b.push_back(e);
    @(posedge clk); #1;
    start_b = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_end(1'b1, 50, lat);
    chk("b_latency", 64'(lat), 64'd4);
    chk("b_done_core", 64'({done_b, crst_b}), 64'b11);
    chk("b_q_empty", 64'(q_b.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eeprom_preload_ctrl.md
# eeprom_preload_ctrl

Boot-time image loader that fetches a parametrised number of words from an external serial EEPROM and writes them into an on-chip memory before releasing the core from reset. Drives a generic byte-read request/response port served by the I2C master; assembles bytes into WIDTH-bit words and retries failed byte reads a bounded number of times. Sits between the I2C master, the boot memory write port and the core reset input.

## Interface
- WIDTH, 32: memory word width in bits; multiple of 8, range 8..64.
- NUM_WORDS, 256: number of words loaded; at least 1.
- BASE_ADDR, 16'h0000: EEPROM byte address of word 0.
- MAX_RETRIES, 3: retries per byte after an error response; 0 means no retry.
- ADDR_W, $clog2(NUM_WORDS) (minimum 1): memory address width; derived, not overridden.

- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  launch pulse; honoured only in IDLE and FAIL.
- rd_req_valid_o  out  1  byte read request valid.
- rd_req_ready_i  in  1  request accepted when high with valid.
- rd_req_addr_o  out  16  EEPROM byte address.
- rd_rsp_valid_i  in  1  response strobe, single cycle.
- rd_rsp_data_i  in  8  response byte.
- rd_rsp_err_i  in  1  NACK/bus error; qualified by rd_rsp_valid_i.
- mem_we_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  word index.
- mem_wdata_o  out  WIDTH  assembled word.
- busy_o  out  1  load in progress.
- done_o  out  1  load completed.
- error_o  out  1  load aborted.
- core_rst_no  out  1  core reset, active-low; released only after successful load.

## Operation
- BPW = WIDTH/8. Byte b of word w is read from BASE_ADDR + w*BPW + b (16-bit, no wrap); elaboration assertion that BASE_ADDR + NUM_WORDS*BPW <= 2^16.
- Little-endian assembly: byte b lands in mem_wdata_o[8b+7:8b].
- States: IDLE, REQ, WAIT, WRITE, DONE, FAIL.
- IDLE: start_i -> REQ with word, byte and retry counters cleared.
- REQ: rd_req_valid_o=1, address stable; rd_req_ready_i -> WAIT.
- WAIT: rd_rsp_valid_i & !rd_rsp_err_i -> capture byte, clear retry counter; last byte -> WRITE, else byte+1 -> REQ.
- WAIT: rd_rsp_valid_i & rd_rsp_err_i -> if retry < MAX_RETRIES, retry+1 and REQ same address; else FAIL.
- WRITE: mem_we_o=1 for exactly one cycle, mem_addr_o=word; last word -> DONE, else word+1, byte 0 -> REQ.
- DONE: done_o=1, core_rst_no=1; terminal until reset; start_i ignored.
- FAIL: error_o=1, core_rst_no=0; start_i restarts from word 0 with counters cleared and error_o dropping.
- busy_o=1 in REQ, WAIT, WRITE.
- rd_rsp_valid_i outside WAIT is ignored. start_i in REQ/WAIT/WRITE/DONE is ignored.
- mem_wdata_o/mem_addr_o are don't-care when mem_we_o=0. Partially assembled words are never written.

## Timing
- Reset values: state IDLE; rd_req_valid_o, mem_we_o, busy_o, done_o, error_o = 0; core_rst_no = 0; counters and data register 0.
- Reset mid-load aborts immediately: core_rst_no stays 0, no further mem_we_o.
- All outputs are registered or decoded from state registers only, with no combinational path from inputs to outputs.
- start_i high in cycle T: REQ from T+1.
- A response in the cycle a request is accepted is ignored; the earliest usable response is one cycle later.
- With ready always high and responses one cycle after acceptance: 2 cycles per byte, 2*BPW+1 cycles per word, DONE (done_o, core_rst_no high) at T+1+NUM_WORDS*(2*BPW+1).
- Each retry adds at least 2 cycles. Ready low stretches REQ indefinitely, with no timeout.

## Test plan
- WIDTH=32, NUM_WORDS=4, bytes 0x00..0x0F, zero-wait responder; start at T -> writes 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C to addresses 0..3; done_o and core_rst_no high at T+37.
- Same config, rd_req_ready_i low for 5 cycles on each request -> address held stable during the stall; data identical; done_o at T+37+16*5.
- MAX_RETRIES=3, byte at address 5 errors twice then succeeds -> word 1 = 0x07060504; no error_o; done_o at T+41.
- Byte at address 5 errors 4 times -> FAIL, error_o=1, core_rst_no=0, only word 0 written; start_i -> full reload succeeds.
- rst_ni low during word 2 -> all outputs at reset values; re-start reloads from address 0.
- WIDTH=8, NUM_WORDS=1, BASE_ADDR=16'hFFFF -> single read at 0xFFFF, one write, done_o at T+4; spurious rd_rsp_valid_i in IDLE has no effect.
